capture_mem: RTL and testbench

Capture side of the internal logic analyzer: samples a probe bus every clock into a circular sample buffer, waits for a masked-match trigger, records a programmed number of post-trigger samples, then freezes. On completion it exports the frozen buffer and `waddr`, the address of the oldest sample. The read side walks the buffer starting at `waddr`, so samples come out in chronological order.

---
 rtl/capture_mem_pkg.sv | 23 ++
 rtl/capture_mem_trigger_match.sv | 13 +
 rtl/capture_mem.sv | 125 ++++++++++++
 tb/tb_capture_mem.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/capture_mem_pkg.sv
// Shared constants and state encoding for the logic-analyzer capture block.
// The read side imports this to decode capture status.
package capture_mem_pkg;

  localparam int unsigned CAP_DATA_WIDTH  = 8;
  localparam int unsigned CAP_ADDR_WIDTH  = 4;
  localparam int unsigned CAP_MEMORY_SIZE = 16;

  typedef enum logic [2:0] {
    CAP_IDLE  = 3'd0,
    CAP_FILL  = 3'd1,
    CAP_ARMED = 3'd2,
    CAP_POST  = 3'd3,
    CAP_DONE  = 3'd4
  } cap_state_e;

  typedef struct packed {
    logic busy;
    logic triggered;
    logic done;
  } cap_status_t;

endpackage

// File: rtl/capture_mem_trigger_match.sv
// Combinational masked compare of the probe bus; shared by multi-stage triggers.
module trigger_match #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] trigger_mask,
  input  logic [DATA_WIDTH-1:0] trigger_value,
  output logic                  hit
);

  assign hit = (((i_data ^ trigger_value) & trigger_mask) == '0);

endmodule

// File: rtl/capture_mem.sv
// Capture side of the logic analyzer: circular pre-trigger buffer, masked trigger,
// post-trigger countdown, then a frozen buffer with the oldest-sample address.
module capture_mem
  import capture_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = CAP_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = CAP_ADDR_WIDTH,
  parameter int unsigned MEMORY_SIZE = CAP_MEMORY_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] trigger_mask,
  input  logic [DATA_WIDTH-1:0] trigger_value,
  input  logic [ADDR_WIDTH-1:0] post_count,
  output logic [DATA_WIDTH-1:0] memory [MEMORY_SIZE],
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  cap_state_e            state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] pre_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] post_q;
  logic [ADDR_WIDTH-1:0] pre_c;
  logic [ADDR_WIDTH-1:0] pre_arm_c;
  logic                  hit_c;
  logic                  capturing_c;

  trigger_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trigger_match (
    .i_data       (i_data),
    .trigger_mask (trigger_mask),
    .trigger_value(trigger_value),
    .hit          (hit_c)
  );

  // Pre-trigger depth for the running capture and for a capture about to be armed.
  assign pre_c       = LAST_ADDR - post_q;
  assign pre_arm_c   = LAST_ADDR - post_count;
  assign capturing_c = (state == CAP_FILL) || (state == CAP_ARMED) || (state == CAP_POST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CAP_IDLE;
      wptr      <= '0;
      waddr     <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      post_q    <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i < MEMORY_SIZE; i++) begin
        memory[i] <= '0;
      end
    end else begin
      // Every capturing edge stores the probe and advances the circular pointer.
      if (capturing_c) begin
        memory[wptr] <= i_data;
        wptr         <= wptr + ONE;
      end

      case (state)
        CAP_IDLE, CAP_DONE: begin
          if (arm) begin
            post_q    <= post_count;
            wptr      <= '0;
            pre_cnt   <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= (pre_arm_c == '0) ? CAP_ARMED : CAP_FILL;
          end
        end

        CAP_FILL: begin
          pre_cnt <= pre_cnt + ONE;
          if ((pre_cnt + ONE) == pre_c) begin
            state <= CAP_ARMED;
          end
        end

        CAP_ARMED: begin
          if (hit_c) begin
            triggered <= 1'b1;
            post_cnt  <= post_q;
            if (post_q == '0) begin
              state <= CAP_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              waddr <= wptr + ONE;
            end else begin
              state <= CAP_POST;
            end
          end
        end

        CAP_POST: begin
          post_cnt <= post_cnt - ONE;
          if (post_cnt == ONE) begin
            state <= CAP_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            waddr <= wptr + ONE;
          end
        end

        default: begin
          state <= CAP_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_mem.sv
// Self-checking bench for capture_mem: scoreboard of written samples versus the frozen buffer.
module tb_capture_mem;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned MS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm;
  logic [DW-1:0] i_data;
  logic [DW-1:0] trigger_mask;
  logic [DW-1:0] trigger_value;
  logic [AW-1:0] post_count;
  logic [DW-1:0] memory [MS];
  logic [AW-1:0] waddr;
  logic          busy;
  logic          triggered;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] hist [$];

  capture_mem dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .i_data       (i_data),
    .trigger_mask (trigger_mask),
    .trigger_value(trigger_value),
    .post_count   (post_count),
    .memory       (memory),
    .waddr        (waddr),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hit(input logic [DW-1:0] d, input logic [DW-1:0] m,
                                   input logic [DW-1:0] v);
    return ((d ^ v) & m) == '0;
  endfunction

  task automatic check_cleared(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < MS; i++) if (memory[i] != '0) nz++;
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".triggered"}, 32'(triggered), 32'd0);
    check({tag, ".done"},      32'(done),      32'd0);
    check({tag, ".waddr"},     32'(waddr),     32'd0);
    check({tag, ".mem_nz"},    32'(nz),        32'd0);
  endtask

  // Arms a capture on a ramp probe; expected buffer comes from the pushed sample history.
  task automatic run_capture(input string tag, input logic [AW-1:0] post,
                             input logic [DW-1:0] mask, input logic [DW-1:0] value,
                             input bit glitch_arm);
    int pre, tidx, exp_writes, n, trig_n, done_n;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_val;
    pre  = int'(MS) - 1 - int'(post);
    tidx = -1;
    for (int k = pre; k < 512 && tidx < 0; k++)
      if (model_hit(DW'(k), mask, value)) tidx = k;
    exp_writes = tidx + int'(post) + 1;
    exp_waddr  = AW'(exp_writes);
    hist.delete();

    arm = 1'b1; post_count = post; trigger_mask = mask; trigger_value = value; i_data = 8'hA5;
    @(negedge clk);
    arm = 1'b0;
    check({tag, ".arm_busy"},      32'(busy),      32'd1);
    check({tag, ".arm_done"},      32'(done),      32'd0);
    check({tag, ".arm_triggered"}, 32'(triggered), 32'd0);
    post_count = ~post;

    n = 0; trig_n = -1; done_n = -1;
    while (done_n < 0 && n < 400) begin
      i_data = DW'(n);
      hist.push_back(DW'(n));
      arm = glitch_arm && (n == tidx + 2);
      @(negedge clk);
      n++;
      if (triggered && trig_n < 0) trig_n = n;
      if (done) done_n = n;
    end
    arm = 1'b0;
    check({tag, ".trig_edge"}, 32'(trig_n), 32'(tidx + 1));
    check({tag, ".done_edge"}, 32'(done_n), 32'(exp_writes));
    check({tag, ".busy_end"},  32'(busy),   32'd0);
    check({tag, ".waddr"},     32'(waddr),  32'(exp_waddr));

    // Buffer must stay frozen while idle in DONE.
    repeat (3) begin
      i_data = 8'hEE;
      @(negedge clk);
    end
    check({tag, ".done_hold"}, 32'(done), 32'd1);

    while (hist.size() > MS) void'(hist.pop_front());
    for (int i = 0; i < MS && hist.size() > 0; i++) begin
      exp_val = hist.pop_front();
      check($sformatf("%s.mem[%0d]", tag, i), 32'(memory[AW'(int'(exp_waddr) + i)]), 32'(exp_val));
    end
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; i_data = '0; trigger_mask = '0; trigger_value = '0; post_count = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);
    check_cleared("idle");

    run_capture("ramp", 4'd4, 8'hFF, 8'h20, 1'b1);
    check("ramp.waddr_abs", 32'(waddr),     32'd5);
    check("ramp.mem5",      32'(memory[5]), 32'h15);
    check("ramp.trig_mem0", 32'(memory[0]), 32'h20);

    run_capture("mask0", 4'd4, 8'h00, 8'h00, 1'b0);
    check("mask0.waddr_abs", 32'(waddr), 32'd0);

    run_capture("pre0", 4'd15, 8'h00, 8'h00, 1'b0);
    check("pre0.trig_first", 32'(memory[0]), 32'h00);

    run_capture("post0", 4'd0, 8'h00, 8'h00, 1'b0);
    run_capture("fill_trig", 4'd4, 8'h0F, 8'h03, 1'b0);
    check("fill_trig.trig_mem", 32'(memory[3]), 32'h13);

    // Reset while in POST aborts the capture.
    arm = 1'b1; post_count = 4'd4; trigger_mask = 8'hFF; trigger_value = 8'h20;
    @(negedge clk);
    arm = 1'b0;
    for (int n = 0; n < 34; n++) begin
      i_data = DW'(n);
      @(negedge clk);
    end
    check("midpost.busy", 32'(busy), 32'd1);
    check("midpost.triggered", 32'(triggered), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("midpost_reset");
    @(negedge clk);
    check_cleared("midpost_idle");

    run_capture("rearm", 4'd4, 8'hFF, 8'h20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
